// File: rtl/param_up_down_counter.sv
// Parametrised up/down counter with modulus MAX, parallel load, terminal-count pulse and 7-seg direction glyph.
// Optional PUDC_SATURATE_EN: hold at the boundary instead of wrapping.
module param_up_down_counter #(
  parameter int WIDTH = 4,
  parameter int MAX   = 2**WIDTH-1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             updown,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic [6:0]       seven,
  output logic             dp
);

  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
  localparam logic [6:0]       SEG_U  = 7'b1000001;
  localparam logic [6:0]       SEG_D  = 7'b0100001;
  localparam logic [6:0]       SEG_BL = 7'b1111111;

  logic [WIDTH-1:0] nxt_out;
  logic             nxt_tc;

  always_comb begin
    nxt_out = out;
    nxt_tc  = 1'b0;
    if (load) begin
      nxt_out = (load_val > MAX_V) ? MAX_V : load_val;
    end else if (en) begin
      if (updown) begin
        if (out >= MAX_V) begin
          nxt_tc = 1'b1;
`ifdef PUDC_SATURATE_EN
          nxt_out = MAX_V;
`else
          nxt_out = '0;
`endif
        end else begin
          nxt_out = out + WIDTH'(1);
        end
      end else begin
        if (out == '0) begin
          nxt_tc = 1'b1;
`ifdef PUDC_SATURATE_EN
          nxt_out = '0;
`else
          nxt_out = MAX_V;
`endif
        end else begin
          nxt_out = out - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out   <= '0;
      tc    <= 1'b0;
      seven <= SEG_BL;
      dp    <= 1'b1;
    end else begin
      out   <= nxt_out;
      tc    <= nxt_tc;
      seven <= updown ? SEG_U : SEG_D;
      // decimal point tracks tc in the same cycle
      dp    <= ~nxt_tc;
    end
  end

endmodule

// File: tb/tb_param_up_down_counter.sv
// Directed bench for param_up_down_counter; wrap tests by default, saturation tests with PUDC_SATURATE_EN.
module tb_param_up_down_counter;
  localparam int WIDTH = 4;
`ifdef PUDC_SATURATE_EN
  localparam int MAX = 15;
`else
  localparam int MAX = 9;
`endif
  localparam logic [6:0] SEG_U  = 7'b1000001;
  localparam logic [6:0] SEG_D  = 7'b0100001;
  localparam logic [6:0] SEG_BL = 7'b1111111;

  logic             clk = 1'b0;
  logic             rst, en, load, updown;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] out;
  logic             tc, dp;
  logic [6:0]       seven;

  int n_cmp = 0;
  int n_bad = 0;

  param_up_down_counter #(.WIDTH(WIDTH), .MAX(MAX)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
    .updown(updown), .out(out), .tc(tc), .seven(seven), .dp(dp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int v);
    load = 1'b1; load_val = WIDTH'(v); en = 1'b0;
    tick();
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b0; en = 1'b1; load = 1'b1; load_val = 4'd5; updown = 1'b1;
    tick(); tick();
    chk("rst_out", int'(out), 0);
    chk("rst_tc", int'(tc), 0);
    chk("rst_seven", int'(seven), int'(SEG_BL));
    chk("rst_dp", int'(dp), 1);

`ifndef PUDC_SATURATE_EN
    // up wrap
    rst = 1'b1; load = 1'b0; en = 1'b1; updown = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk($sformatf("up_out%0d", i), int'(out), i % 10);
      chk($sformatf("up_tc%0d", i), int'(tc), (i == 10) ? 1 : 0);
      chk($sformatf("up_dp%0d", i), int'(dp), (i == 10) ? 0 : 1);
      chk($sformatf("up_seg%0d", i), int'(seven), int'(SEG_U));
    end

    // load clamp then down wrap
    do_load(15);
    chk("clamp_out", int'(out), 9);
    chk("clamp_tc", int'(tc), 0);
    do_load(1);
    chk("load1", int'(out), 1);
    en = 1'b1; updown = 1'b0;
    tick(); chk("dn_out0", int'(out), 0); chk("dn_tc0", int'(tc), 0);
    tick(); chk("dn_out9", int'(out), 9); chk("dn_tc9", int'(tc), 1);
    chk("dn_dp9", int'(dp), 0);
    tick(); chk("dn_out8", int'(out), 8); chk("dn_tc8", int'(tc), 0);
    chk("dn_seg", int'(seven), int'(SEG_D));

    // load beats count, then hold
    do_load(5);
    chk("pri_pre", int'(out), 5);
    load = 1'b1; load_val = 4'd2; en = 1'b1; updown = 1'b1;
    tick(); load = 1'b0;
    chk("pri_out", int'(out), 2);
    chk("pri_tc", int'(tc), 0);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("hold_out%0d", i), int'(out), 2);
      chk($sformatf("hold_tc%0d", i), int'(tc), 0);
      chk($sformatf("hold_seg%0d", i), int'(seven), int'(SEG_U));
    end

    // reverse at MAX: plain decrement, no tc
    do_load(9);
    en = 1'b1; updown = 1'b0;
    tick();
    chk("rev_out", int'(out), 8);
    chk("rev_tc", int'(tc), 0);

    // reset at the wrap edge cancels the tc pulse
    do_load(8);
    en = 1'b1; updown = 1'b1;
    tick(); chk("mid_pre", int'(out), 9);
    rst = 1'b0;
    tick();
    chk("mid_out", int'(out), 0);
    chk("mid_tc", int'(tc), 0);
    chk("mid_dp", int'(dp), 1);
    chk("mid_seg", int'(seven), int'(SEG_BL));
    rst = 1'b1;
    tick();
    chk("post_rst", int'(out), 1);
`else
    rst = 1'b1; updown = 1'b1;
    do_load(14);
    chk("sat_pre", int'(out), 14);
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("sat_out%0d", i), int'(out), 15);
      chk($sformatf("sat_tc%0d", i), int'(tc), (i == 0) ? 0 : 1);
      chk($sformatf("sat_dp%0d", i), int'(dp), (i == 0) ? 1 : 0);
    end
    do_load(0);
    en = 1'b1; updown = 1'b0;
    tick();
    chk("satdn_out", int'(out), 0);
    chk("satdn_tc", int'(tc), 1);
    chk("satdn_seg", int'(seven), int'(SEG_D));
    en = 1'b0;
    tick();
    chk("satdn_hold_tc", int'(tc), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
